// File: rtl/mips_pkg.sv
// Shared definitions for the fetch stage.
// Covers the word width, the fetch FSM encoding and the NOP word.
package mips_pkg;

    localparam int WORD_W = 32;

    localparam logic [WORD_W-1:0] NOP = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fetch_state_t;

    function automatic logic pc_in_imem(input logic [WORD_W-1:0] pc,
                                        input logic [WORD_W-1:0] depth);
        return pc < depth;
    endfunction

endpackage

// File: rtl/fetch_reg.sv
// Fetch-to-decode pipeline register with a valid/ready handshake.
// Flush takes priority over load. Load takes priority over draining on a transfer.
module fetch_reg
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              flush,
    input  logic              out_ready,
    input  logic [WORD_W-1:0] in_instruction,
    input  logic [WORD_W-1:0] in_pc,
    output logic              out_valid,
    output logic [WORD_W-1:0] out_instruction,
    output logic [WORD_W-1:0] out_pc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid       <= 1'b0;
            out_instruction <= NOP;
            out_pc          <= '0;
        end else if (flush) begin
            // Data is left in place; only the valid bit is dropped.
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid       <= 1'b1;
            out_instruction <= in_instruction;
            out_pc          <= in_pc;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the pc, feeds read_instructions and the decode register.
// Handles branch/jump redirects and stops at the end of the loaded program.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | after reset; nothing fetched until start
//   ST_RUN  | fetching one word per cycle while decode keeps up
//   ST_DONE | pc past the program and fetch register drained; done=1
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC   = 32'd0,
    parameter logic [WORD_W-1:0] IMEM_DEPTH = 32'd3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [WORD_W-1:0] imem_pc,
    input  logic [WORD_W-1:0] imem_instruction,
    input  logic              redirect_valid,
    input  logic [WORD_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_instruction,
    output logic [WORD_W-1:0] out_pc,
    output logic [WORD_W-1:0] fetch_count,
    output logic              done
);

    fetch_state_t      state, state_nxt;
    logic [WORD_W-1:0] pc_reg, pc_nxt;
    logic              advance, redir_take, flush, xfer, pc_ok, slot_free;

    assign imem_pc   = pc_reg;
    assign done      = (state == ST_DONE);
    assign xfer      = out_valid && out_ready;
    assign pc_ok     = pc_in_imem(pc_reg, IMEM_DEPTH);
    assign slot_free = !out_valid || out_ready;
    assign flush     = start || redir_take;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            pc_reg      <= RESET_PC;
            fetch_count <= '0;
        end else begin
            state  <= state_nxt;
            pc_reg <= pc_nxt;
            if (start)
                fetch_count <= '0;
            else if (xfer)
                fetch_count <= fetch_count + 32'd1;
        end
    end

    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc_reg;
        advance    = 1'b0;
        redir_take = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_RUN;
                    pc_nxt    = RESET_PC;
                end
            end
            ST_RUN: begin
                if (start) begin
                    pc_nxt = RESET_PC;
                end else if (redirect_valid) begin
                    // Out-of-range targets are accepted here and retire to DONE next cycle.
                    redir_take = 1'b1;
                    pc_nxt     = redirect_pc;
                end else if (pc_ok && slot_free) begin
                    advance = 1'b1;
                    pc_nxt  = pc_reg + 32'd1;
                end else if (!pc_ok && slot_free) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_nxt = ST_RUN;
                    pc_nxt    = RESET_PC;
                end else if (redirect_valid && pc_in_imem(redirect_pc, IMEM_DEPTH)) begin
                    state_nxt  = ST_RUN;
                    redir_take = 1'b1;
                    pc_nxt     = redirect_pc;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    fetch_reg u_fetch_reg (
        .clk             (clk),
        .rst_n           (rst_n),
        .load            (advance),
        .flush           (flush),
        .out_ready       (out_ready),
        .in_instruction  (imem_instruction),
        .in_pc           (pc_reg),
        .out_valid       (out_valid),
        .out_instruction (out_instruction),
        .out_pc          (out_pc)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed table-driven bench for fetch_unit with a 3-word instruction memory model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] imem_pc;
    logic [31:0] imem_instruction;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instruction;
    logic [31:0] out_pc;
    logic [31:0] fetch_count;
    logic        done;

    localparam logic [31:0] M0 = 32'h2008_0005;
    localparam logic [31:0] M1 = 32'h2009_0003;
    localparam logic [31:0] M2 = 32'h0109_5020;

    logic [31:0] mem [0:2];
    initial begin
        mem[0] = M0;
        mem[1] = M1;
        mem[2] = M2;
    end

    // Out-of-range words read as a poison value so a bad capture is visible.
    assign imem_instruction = (imem_pc < 32'd3) ? mem[imem_pc[1:0]] : 32'hDEAD_BEEF;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'd0), .IMEM_DEPTH(32'd3)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .imem_pc          (imem_pc),
        .imem_instruction (imem_instruction),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_instruction  (out_instruction),
        .out_pc           (out_pc),
        .fetch_count      (fetch_count),
        .done             (done)
    );

    typedef struct {
        logic        st;
        logic        rdy;
        logic        rv;
        logic [31:0] rpc;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic [31:0] e_count;
        logic        e_done;
        logic [31:0] e_imem_pc;
    } vec_t;

    vec_t vecs [0:32];
    int   n_pass = 0;
    int   n_total = 0;

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s row %0d: got %h want %h", name, row, act, exp);
    endtask

    task automatic chk_all(input int row, input logic ev, input logic [31:0] epc, input logic [31:0] ein,
                           input logic [31:0] ecnt, input logic edone, input logic [31:0] eimem);
        chk("out_valid", row, {31'd0, out_valid}, {31'd0, ev});
        chk("out_pc", row, out_pc, epc);
        chk("out_instruction", row, out_instruction, ein);
        chk("fetch_count", row, fetch_count, ecnt);
        chk("done", row, {31'd0, done}, {31'd0, edone});
        chk("imem_pc", row, imem_pc, eimem);
    endtask

    task automatic run_rows(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            start          = vecs[i].st;
            out_ready      = vecs[i].rdy;
            redirect_valid = vecs[i].rv;
            redirect_pc    = vecs[i].rpc;
            @(posedge clk);
            @(negedge clk);
            start          = 1'b0;
            redirect_valid = 1'b0;
            chk_all(i, vecs[i].e_valid, vecs[i].e_pc, vecs[i].e_instr,
                    vecs[i].e_count, vecs[i].e_done, vecs[i].e_imem_pc);
        end
    endtask

    initial begin
        //            st    rdy   rv    rpc    ev    epc    einstr  ecnt   edone eimem
        // full run from start
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 32'd0, M0,    32'd0, 1'b0, 32'd1};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 32'd1, M1,    32'd1, 1'b0, 32'd2};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 32'd2, M2,    32'd2, 1'b0, 32'd3};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd2, M2,    32'd3, 1'b1, 32'd3};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd2, M2,    32'd3, 1'b1, 32'd3};
        // restart from DONE with backpressure
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd2, M2,    32'd0, 1'b0, 32'd0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'd0, M0,    32'd0, 1'b0, 32'd1};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'd0, M0,    32'd0, 1'b0, 32'd1};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'd0, M0,    32'd0, 1'b0, 32'd1};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'd0, M0,    32'd0, 1'b0, 32'd1};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 32'd1, M1,    32'd1, 1'b0, 32'd2};
        // redirect to 0 while out_pc=1 is being accepted
        vecs[12] = '{1'b0, 1'b1, 1'b1, 32'd0, 1'b0, 32'd1, M1,    32'd2, 1'b0, 32'd0};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 32'd0, M0,    32'd2, 1'b0, 32'd1};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 32'd1, M1,    32'd3, 1'b0, 32'd2};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 32'd2, M2,    32'd4, 1'b0, 32'd3};
        vecs[16] = '{1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd2, M2,    32'd5, 1'b1, 32'd3};
        // in-range redirect out of DONE
        vecs[17] = '{1'b0, 1'b1, 1'b1, 32'd1, 1'b0, 32'd2, M2,    32'd5, 1'b0, 32'd1};
        vecs[18] = '{1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 32'd1, M1,    32'd5, 1'b0, 32'd2};
        // out-of-range redirect
        vecs[19] = '{1'b0, 1'b0, 1'b1, 32'd7, 1'b0, 32'd1, M1,    32'd5, 1'b0, 32'd7};
        vecs[20] = '{1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd1, M1,    32'd5, 1'b1, 32'd7};
        vecs[21] = '{1'b0, 1'b1, 1'b1, 32'd7, 1'b0, 32'd1, M1,    32'd5, 1'b1, 32'd7};
        // start beats redirect and a same-cycle transfer while running
        vecs[22] = '{1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd1, M1,    32'd0, 1'b0, 32'd0};
        vecs[23] = '{1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 32'd0, M0,    32'd0, 1'b0, 32'd1};
        vecs[24] = '{1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 32'd1, M1,    32'd1, 1'b0, 32'd2};
        vecs[25] = '{1'b1, 1'b1, 1'b1, 32'd2, 1'b0, 32'd1, M1,    32'd0, 1'b0, 32'd0};
        vecs[26] = '{1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 32'd0, M0,    32'd0, 1'b0, 32'd1};
        vecs[27] = '{1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 32'd1, M1,    32'd1, 1'b0, 32'd2};
        // after async reset: fresh run
        vecs[28] = '{1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0};
        vecs[29] = '{1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 32'd0, M0,    32'd0, 1'b0, 32'd1};
        vecs[30] = '{1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 32'd1, M1,    32'd1, 1'b0, 32'd2};
        vecs[31] = '{1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 32'd2, M2,    32'd2, 1'b0, 32'd3};
        vecs[32] = '{1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd2, M2,    32'd3, 1'b1, 32'd3};

        repeat (2) @(negedge clk);
        chk_all(-1, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk_all(-2, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0);

        run_rows(0, 27);

        // Mid-cycle async reset with out_valid=1 and pc=2.
        #2;
        rst_n = 1'b0;
        #1;
        chk_all(100, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk_all(101 + k, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0);
        end

        run_rows(28, 32);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
